function_select_sequencer: RTL and testbench
============================================

// Module: function_select_sequencer
// PURPOSE
//  Sequences the function-selection input of the selector stage. It replaces a raw `sel` level with a
//  debounced, datapath-safe toggle:
//   - a pushbutton press is synchronised and debounced;
//   - the switch is held off until the active function datapath reports idle;
//   - `sel` is flipped once per press;
//   - a settle window is enforced before the new function is declared valid.
//  Sits between board I/O and the selector; `sel` drives the selector directly.
// PARAMETERS
//  DB_CYCLES      4      consecutive stable cycles to accept a press/release (>=2)
//  SETTLE_CYCLES  3      cycles sel_valid stays low after a toggle (>=1)
//  AUTO_PERIOD    1000   idle cycles between automatic toggles (only with AUTO_TOGGLE_EN)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  synchronous, active-high reset
//  btn_sel    in   1  raw pushbutton, asynchronous to clk
//  dp_busy    in   1  high while the currently selected datapath is mid-operation
//  sel        out  1  function select to the selector (0/1)
//  sel_valid  out  1  high when sel is stable and the datapath may start work
//  switching  out  1  one-cycle pulse on the edge where sel toggles
//  sw_count   out  8  number of toggles since reset, wraps 255->0
// BEHAVIOUR
//  - Reset (sync, dominant over all inputs):
//      state=IDLE, sel=0, sel_valid=1, switching=0, sw_count=0, counters=0, synchroniser flops=0.
//    Reset mid-operation from any state aborts the pending switch; sel returns to 0.
//  - btn_sel passes a 2-flop synchroniser -> btn_s.
//  - All outputs are registered. sel_valid=1 in IDLE, DEBOUNCE, RELEASE; 0 in WAIT_BUSY, SETTLE.
//  - FSM (one edge per transition):
//    IDLE:      btn_s=1 -> DEBOUNCE, cnt=1.
//    DEBOUNCE:  btn_s=0 -> IDLE (cnt cleared).
//               btn_s=1 and cnt==DB_CYCLES-1 -> WAIT_BUSY.
//               else cnt++.
//    WAIT_BUSY: dp_busy=0 -> sel<=~sel, switching<=1, sw_count++, cnt=0, go SETTLE.
//               dp_busy=1 -> stay; no timeout.
//               btn_s changes here are ignored.
//    SETTLE:    cnt++; on cnt==SETTLE_CYCLES-1 -> RELEASE (cnt cleared).
//               dp_busy is ignored.
//    RELEASE:   cnt counts consecutive btn_s=0 cycles; any btn_s=1 clears cnt.
//               cnt==DB_CYCLES-1 with btn_s=0 -> IDLE.
//  - A held button produces exactly one toggle. A glitch shorter than DB_CYCLES produces none.
//  - Latency: btn_sel first sampled high at edge 0, held, dp_busy=0 ->
//    sel toggles at edge DB_CYCLES+2; sel_valid rises at edge DB_CYCLES+2+SETTLE_CYCLES.
//  - switching is high exactly one cycle per toggle. sw_count increments on the same edge.
//  - dp_busy falling in the same cycle WAIT_BUSY is entered: the toggle occurs on the next edge.
// CONFIGURATION
//  Macro AUTO_TOGGLE_EN.
//  - Defined:
//    - A counter runs only while the FSM is in IDLE and clears on leaving IDLE.
//    - After AUTO_PERIOD consecutive IDLE cycles, the FSM enters WAIT_BUSY directly (no debounce).
//    - An auto-originated switch leaves SETTLE straight to IDLE (skips RELEASE).
//    - btn_s=1 in the same cycle as auto expiry: the button wins (DEBOUNCE).
//  - Undefined:
//    - No auto counter is synthesised; AUTO_PERIOD is unused.
//    - Toggles come only from btn_sel.
// TESTING  (DB_CYCLES=4, SETTLE_CYCLES=3, AUTO_PERIOD=20)
//  1. reset held 3 cycles, then released -> sel=0, sel_valid=1, switching=0, sw_count=0.
//  2. btn_sel=1 held, dp_busy=0 -> sel 0->1 at edge 6, one switching pulse, sw_count=1,
//     sel_valid low edges 5..8, high at edge 9, no second toggle while held.
//  3. btn_sel high 2 cycles then low -> no toggle, sel_valid never drops, sw_count=0.
//  4. press with dp_busy=1 for 10 cycles -> sel_valid=0 and sel unchanged until dp_busy falls;
//     sel toggles on the edge after dp_busy=0 is sampled.
//  5. reset asserted during SETTLE -> next edge sel=0, sel_valid=1, sw_count=0;
//     a subsequent full press toggles normally.
//  6. AUTO_TOGGLE_EN defined, no press, dp_busy=0 -> sel toggles every 20+1+3 cycles;
//     sw_count wraps 255->0 after 256 toggles.

Source files
------------

// File: rtl/function_select_sequencer.sv
// Debounced press -> wait for datapath idle -> toggle sel -> settle window; sel toggles DB_CYCLES+2 edges after a press.
// Optional periodic auto-toggle when AUTO_TOGGLE_EN is defined; dp_busy stalls the switch indefinitely.
module function_select_sequencer #(
  parameter int DB_CYCLES     = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int AUTO_PERIOD   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       dp_busy,
  output logic       sel,
  output logic       sel_valid,
  output logic       switching,
  output logic [7:0] sw_count
);

  localparam int CNT_MAX = (DB_CYCLES > SETTLE_CYCLES) ? DB_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, WAIT_BUSY, SETTLE, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, btn_s;
  logic          sel_nxt, sel_valid_nxt, switching_nxt;
  logic [7:0]    sw_count_nxt;

`ifdef AUTO_TOGGLE_EN
  localparam int AW = $clog2(AUTO_PERIOD + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  logic [AW-1:0] auto_cnt, auto_cnt_nxt;
  logic          auto_sw, auto_sw_nxt;
`else
  localparam int auto_period_unused = AUTO_PERIOD;
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    switching_nxt = 1'b0;
    sw_count_nxt  = sw_count;
`ifdef AUTO_TOGGLE_EN
    auto_cnt_nxt  = '0;
    auto_sw_nxt   = auto_sw;
`endif
    case (state)
      IDLE: begin
        // A button seen in the same cycle as auto expiry takes precedence.
        if (btn_s) begin
          state_nxt = DEBOUNCE;
          cnt_nxt   = CW'(1);
        end
`ifdef AUTO_TOGGLE_EN
        else if (auto_cnt == AUTO_LAST) begin
          state_nxt   = WAIT_BUSY;
          auto_sw_nxt = 1'b1;
        end else begin
          auto_cnt_nxt = auto_cnt + 1'b1;
        end
`endif
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = WAIT_BUSY;
          cnt_nxt   = '0;
`ifdef AUTO_TOGGLE_EN
          auto_sw_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!dp_busy) begin
          state_nxt     = SETTLE;
          sel_nxt       = ~sel;
          switching_nxt = 1'b1;
          sw_count_nxt  = sw_count + 8'd1;
          cnt_nxt       = '0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
`ifdef AUTO_TOGGLE_EN
          // No button to wait out after an automatic switch.
          state_nxt   = auto_sw ? IDLE : RELEASE;
          auto_sw_nxt = 1'b0;
`else
          state_nxt = RELEASE;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (btn_s) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    sel_valid_nxt = (state_nxt != WAIT_BUSY) && (state_nxt != SETTLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      btn_s     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      sel_valid <= 1'b1;
      switching <= 1'b0;
      sw_count  <= 8'd0;
`ifdef AUTO_TOGGLE_EN
      auto_cnt  <= '0;
      auto_sw   <= 1'b0;
`endif
    end else begin
      sync1     <= btn_sel;
      btn_s     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      sel_valid <= sel_valid_nxt;
      switching <= switching_nxt;
      sw_count  <= sw_count_nxt;
`ifdef AUTO_TOGGLE_EN
      auto_cnt  <= auto_cnt_nxt;
      auto_sw   <= auto_sw_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_function_select_sequencer.sv
// Bench for function_select_sequencer: vector table, hand-written corner sequences and
// randomized stimulus checked against a run-length reference model.
module tb_function_select_sequencer;

  localparam int DB = 4;
  localparam int SC = 3;
  localparam int AP = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_sel = 1'b0;
  logic       dp_busy = 1'b0;
  logic       sel, sel_valid, switching;
  logic [7:0] sw_count;

  int n_vec = 0;
  int n_err = 0;

  function_select_sequencer #(
    .DB_CYCLES(DB), .SETTLE_CYCLES(SC), .AUTO_PERIOD(AP)
  ) dut (
    .clk(clk), .reset(reset), .btn_sel(btn_sel), .dp_busy(dp_busy),
    .sel(sel), .sel_valid(sel_valid), .switching(switching), .sw_count(sw_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference model: phases and run lengths of synchronised button samples.
  localparam int PH_ARMED = 0, PH_PENDING = 1, PH_SETTLING = 2, PH_RELEASING = 3;
  int   m_phase, m_hi_run, m_lo_run, m_idle_run, m_settle_left;
  bit   m_auto, m_s1, m_s2, m_sel, m_valid, m_sw;
  int   m_cnt;

  task automatic model_step(input logic r, input logic b, input logic bz);
    bit bs, was_idle;
    if (r) begin
      m_phase = PH_ARMED; m_hi_run = 0; m_lo_run = 0; m_idle_run = 0; m_settle_left = 0;
      m_auto = 0; m_s1 = 0; m_s2 = 0; m_sel = 0; m_valid = 1; m_sw = 0; m_cnt = 0;
      return;
    end
    bs   = m_s2;
    m_sw = 0;
    case (m_phase)
      PH_ARMED: begin
        was_idle = (m_hi_run == 0);
        m_hi_run = bs ? m_hi_run + 1 : 0;
        if (m_hi_run == DB) begin
          m_phase = PH_PENDING; m_auto = 0; m_hi_run = 0; m_idle_run = 0;
        end
`ifdef AUTO_TOGGLE_EN
        else if (was_idle && !bs) begin
          m_idle_run++;
          if (m_idle_run == AP) begin
            m_phase = PH_PENDING; m_auto = 1; m_idle_run = 0;
          end
        end else m_idle_run = 0;
`endif
      end
      PH_PENDING: if (!bz) begin
        m_sel = !m_sel; m_sw = 1; m_cnt = (m_cnt + 1) % 256;
        m_settle_left = SC; m_phase = PH_SETTLING;
      end
      PH_SETTLING: begin
        m_settle_left--;
        if (m_settle_left == 0) begin
          m_phase = m_auto ? PH_ARMED : PH_RELEASING;
          m_auto = 0; m_lo_run = 0; m_hi_run = 0; m_idle_run = 0;
        end
      end
      default: begin
        m_lo_run = bs ? 0 : m_lo_run + 1;
        if (m_lo_run == DB) begin
          m_phase = PH_ARMED; m_hi_run = 0; m_idle_run = 0;
        end
      end
    endcase
    m_valid = (m_phase == PH_ARMED) || (m_phase == PH_RELEASING);
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic step(input logic r, input logic b, input logic bz);
    reset = r; btn_sel = b; dp_busy = bz;
    @(posedge clk);
    model_step(r, b, bz);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sel"}, {7'd0, sel}, {7'd0, m_sel});
    check({tag, ".sel_valid"}, {7'd0, sel_valid}, {7'd0, m_valid});
    check({tag, ".switching"}, {7'd0, switching}, {7'd0, m_sw});
    check({tag, ".sw_count"}, sw_count, 8'(m_cnt));
  endtask

  typedef struct {
    logic rst, btn, busy;
    logic e_sel, e_valid, e_sw;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic r, b, bz, s, v, w, input int c);
    vec_t x;
    x.rst = r; x.btn = b; x.busy = bz; x.e_sel = s; x.e_valid = v; x.e_sw = w; x.e_cnt = 8'(c);
    for (int i = 0; i < n; i++) tbl.push_back(x);
  endtask

  initial begin
    logic prev;
    int   steps, toggles, last_tog;
    bit   hit;

    // Reset for 3 edges, then a held press with dp_busy low; btn first sampled at edge 0.
    add(3, 1, 0, 0, 0, 1, 0, 0);
    add(5, 0, 1, 0, 0, 1, 0, 0);   // edges 0..4: synchroniser + debounce
    add(1, 0, 1, 0, 0, 0, 0, 0);   // edge 5: waiting on datapath
    add(1, 0, 1, 0, 1, 0, 1, 1);   // edge 6: toggle
    add(2, 0, 1, 0, 1, 0, 0, 1);   // edges 7..8: settling
    add(4, 0, 1, 0, 1, 1, 0, 1);   // still held: no second toggle
    add(8, 0, 0, 0, 1, 1, 0, 1);   // release
    add(2, 0, 1, 0, 1, 1, 0, 1);   // 2-cycle glitch
    add(6, 0, 0, 0, 1, 1, 0, 1);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].btn, tbl[i].busy);
      check($sformatf("tbl[%0d].sel", i), {7'd0, sel}, {7'd0, tbl[i].e_sel});
      check($sformatf("tbl[%0d].sel_valid", i), {7'd0, sel_valid}, {7'd0, tbl[i].e_valid});
      check($sformatf("tbl[%0d].switching", i), {7'd0, switching}, {7'd0, tbl[i].e_sw});
      check($sformatf("tbl[%0d].sw_count", i), sw_count, tbl[i].e_cnt);
    end

    // Press while the datapath is busy for 10 cycles.
    prev = sel;
    for (int i = 0; i < 10; i++) begin step(0, 1, 1); check_model("busy"); end
    check("busy_hold_sel", {7'd0, sel}, {7'd0, prev});
    check("busy_hold_valid", {7'd0, sel_valid}, 8'd0);
    step(0, 1, 0);
    check("busy_drop_sel", {7'd0, sel}, {7'd0, ~prev});
    check("busy_drop_switching", {7'd0, switching}, 8'd1);
    for (int i = 0; i < 8; i++) begin step(0, 0, 0); check_model("busy_rel"); end

    // Reset in the middle of the settle window, then a full press with latency checks.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin step(0, 1, 0); hit = (switching === 1'b1); end
    check("settle_reach_toggle", {7'd0, hit}, 8'd1);
    step(0, 1, 0);
    check("settle_valid_low", {7'd0, sel_valid}, 8'd0);
    step(1, 0, 0);
    check("rst_settle.sel", {7'd0, sel}, 8'd0);
    check("rst_settle.sel_valid", {7'd0, sel_valid}, 8'd1);
    check("rst_settle.switching", {7'd0, switching}, 8'd0);
    check("rst_settle.sw_count", sw_count, 8'd0);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); check_model("post_rst"); end
    hit = 0; steps = 0;
    for (int i = 0; i < 20 && !hit; i++) begin step(0, 1, 0); steps++; hit = (switching === 1'b1); end
    check("latency_toggle_steps", 8'(steps), 8'(DB + 3));
    check("post_rst_toggle.sel", {7'd0, sel}, 8'd1);
    check("post_rst_toggle.sw_count", sw_count, 8'd1);
    for (int i = 1; i < SC; i++) step(0, 1, 0);
    check("latency_valid_still_low", {7'd0, sel_valid}, 8'd0);
    step(0, 1, 0);
    check("latency_valid_rise", {7'd0, sel_valid}, 8'd1);

    // Randomized segments against the model.
    for (int seg = 0; seg < 400; seg++) begin
      logic b, busy_mode;
      int   len;
      b = 1'($urandom_range(0, 1));
      busy_mode = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        logic bz, r;
        bz = busy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
        r  = ($urandom_range(0, 299) == 0);
        step(r, b, bz);
        check_model("rand");
      end
    end

`ifdef AUTO_TOGGLE_EN
    // Automatic toggling with no presses: fixed period and sw_count wrap.
    step(1, 0, 0);
    toggles = 0; last_tog = -1;
    for (int i = 0; i < 257 * (AP + 1 + SC) + 40; i++) begin
      step(0, 0, 0);
      check_model("auto");
      if (switching === 1'b1) begin
        toggles++;
        if (last_tog >= 0) check("auto_period", 8'(i - last_tog), 8'(AP + 1 + SC));
        last_tog = i;
        if (toggles == 256) check("auto_wrap", sw_count, 8'd0);
      end
    end
    check("auto_toggle_count_reached", {7'd0, toggles >= 256}, 8'd1);
`else
    toggles = 0; last_tog = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
